pio_in_edge_irq: RTL
====================

PIO_IN_EDGE_IRQ -- requirements
Module: pio_in_edge_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of input bits (legal 1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per bit (legal 2..3).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 0, stable cycles required before a bit change is accepted (legal 0..65535; 0 = bypass).
REQ-004 SHALL have port clk, input, 1, rising-edge system clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_port, input, WIDTH, asynchronous external inputs.
REQ-007 SHALL have port chipselect, input, 1, Avalon-MM slave select.
REQ-008 SHALL have port address, input, 3, word address.
REQ-009 SHALL have port write_n, input, 1, active-low write strobe.
REQ-010 SHALL have port writedata, input, 32, write data; bits above WIDTH ignored.
REQ-011 SHALL have port readdata, output, 32, registered read data; bits above WIDTH read 0.
REQ-012 SHALL have port irq, output, 1, registered level interrupt.

Function
REQ-013 SHALL pass each in_port bit through SYNC_STAGES flops; output = sync[i].
REQ-014 With DEBOUNCE_CYCLES=0, filt[i] SHALL equal sync[i].
REQ-015 With DEBOUNCE_CYCLES=N>0, per-bit counter SHALL clear when sync[i]==filt[i], increment otherwise; on reaching N-1 while differing, filt[i] SHALL take sync[i] next cycle and counter SHALL clear; counter never exceeds N-1.
REQ-016 Register map: 0 data (RO, filt); 1 rise_en (RW); 2 fall_en (RW); 3 edge_capture (RW1C); 4 irq_mask (RW); 5 overflow (RW1C); 6,7 reserved, read 0, writes ignored.
REQ-017 Write occurs when chipselect=1 and write_n=0; writes to RO/reserved addresses SHALL have no effect.
REQ-018 readdata SHALL update every cycle to the mux of address, i.e. valid one cycle after address is presented; no read side effects.
REQ-019 filt_d SHALL be filt delayed one cycle; edge[i] = (rise_en[i] & filt[i] & ~filt_d[i]) | (fall_en[i] & ~filt[i] & filt_d[i]).
REQ-020 edge_capture[i] SHALL set the cycle after edge[i]; SHALL clear on write of 1 to bit i at address 3; write of 0 leaves bit unchanged.
REQ-021 Simultaneous edge[i] and W1C of bit i SHALL leave edge_capture[i]=1 (set wins).
REQ-022 overflow[i] SHALL set when edge[i] occurs while edge_capture[i]=1 and bit i is not being cleared that cycle; cleared by W1C at address 5; set wins over clear.
REQ-023 irq SHALL be registered |(edge_capture & irq_mask), asserting one cycle after the capture bit or mask bit becomes 1.
REQ-024 Total latency, in_port toggle to edge_capture set, SHALL be SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (DEBOUNCE_CYCLES=0: SYNC_STAGES+1).
REQ-025 Changing rise_en/fall_en SHALL affect edge detection starting the cycle after the write; it SHALL NOT itself generate an edge.

Reset
REQ-026 reset_n low SHALL asynchronously clear all sync flops, filt, filt_d, debounce counters, rise_en, fall_en, edge_capture, irq_mask, overflow, readdata and irq to 0.
REQ-027 Reset release with in_port high and rise_en=0 SHALL produce no capture; edges are enabled only after software sets rise_en/fall_en.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; no capture from the pending change.

Structure
REQ-029 Package pio_in_pkg SHALL hold register address constants (ADDR_DATA..ADDR_OVF), the 3-bit address width and the debounce counter width function (ceil log2 of DEBOUNCE_CYCLES, minimum 1).
REQ-030 Sub-module pio_debounce SHALL implement synchronizer plus debounce for one bit, instantiated WIDTH times by generate; register file, edge logic and readback stay in the top.

Verification
REQ-031 WIDTH=8, SYNC=2, DEB=0, rise_en=0xFF: in_port 0x00->0x01 -> edge_capture=0x01 exactly 3 cycles later; read addr 3 returns 0x00000001.
REQ-032 fall_en=0x80 only, irq_mask=0x80: in_port bit7 1->0 -> capture=0x80, irq=1 next cycle; W1C 0x80 at addr 3 -> capture=0, irq=0 one cycle later.
REQ-033 DEB=4: bit0 pulse high 3 cycles -> no data change, no capture; high 4 cycles -> data bit0=1 and capture bit0 set.
REQ-034 Second rising edge on bit2 before clear -> overflow=0x04; edge on bit2 coinciding with W1C of bit2 -> capture bit2 stays 1.
REQ-035 Write 0xFFFFFFFF to addr 0 and addr 6 -> registers unchanged, reads of addr 6/7 return 0; WIDTH=32 rise_en=0xFFFFFFFF all bits toggle -> capture=0xFFFFFFFF.
REQ-036 Assert reset_n low during debounce count and with capture/irq set -> all registers, readdata and irq read 0 immediately; no capture after release.

Source files
------------

// File: rtl/pio_in_pkg.sv
// Shared constants for the edge-capturing parallel input port.
// Register word addresses, address width and debounce counter sizing.
package pio_in_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_FALL = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CAP  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OVF  = 3'd5;

    // ceil(log2(n)), never less than 1
    function automatic int deb_cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// One-bit synchronizer followed by an optional stable-count debouncer.
// Ports: clk, reset_n (async low), in_i (async pin), filt_o (filtered bit).
module pio_debounce
    import pio_in_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic filt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filt_o = sync;
        end else begin : g_deb
            localparam int CW = deb_cnt_w(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          filt_q;
            logic          filt_d;

            // Any sample agreeing with the filtered value restarts the count.
            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (sync != filt_q) begin
                    if (cnt_q == LAST) begin
                        filt_d = sync;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filt_o = filt_q;
        end
    endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Parallel input port with per-bit edge capture, overflow and level irq.
// Ports: clk, reset_n, in_port, Avalon-MM slave (chipselect, address,
// write_n, writedata, readdata), irq.
module pio_in_edge_irq
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in_port,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_dly_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] ovf_q;
    logic [WIDTH-1:0] ovf_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] ovf_clr;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_d;
    logic             irq_d;
    logic             wr;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .in_i   (in_port[i]),
            .filt_o (filt[i])
        );
    end

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        edge_hit = (rise_q & filt & ~filt_dly_q)
                 | (fall_q & ~filt & filt_dly_q);
        cap_clr  = (wr && address == ADDR_CAP) ? wdata : '0;
        ovf_clr  = (wr && address == ADDR_OVF) ? wdata : '0;
        // A new edge always wins over a same-cycle clear.
        cap_d    = (cap_q & ~cap_clr) | edge_hit;
        ovf_d    = (ovf_q & ~ovf_clr) | (edge_hit & cap_q & ~cap_clr);
        irq_d    = |(cap_q & mask_q);
    end

    always_comb begin
        rd_d = '0;
        case (address)
            ADDR_DATA: rd_d = 32'(filt);
            ADDR_RISE: rd_d = 32'(rise_q);
            ADDR_FALL: rd_d = 32'(fall_q);
            ADDR_CAP:  rd_d = 32'(cap_q);
            ADDR_MASK: rd_d = 32'(mask_q);
            ADDR_OVF:  rd_d = 32'(ovf_q);
            default:   rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_dly_q <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            ovf_q      <= '0;
            readdata   <= '0;
            irq        <= 1'b0;
        end else begin
            filt_dly_q <= filt;
            cap_q      <= cap_d;
            ovf_q      <= ovf_d;
            readdata   <= rd_d;
            irq        <= irq_d;
            if (wr && address == ADDR_RISE) rise_q <= wdata;
            if (wr && address == ADDR_FALL) fall_q <= wdata;
            if (wr && address == ADDR_MASK) mask_q <= wdata;
        end
    end

endmodule
